br_redirect_ctrl: RTL and testbench

Sequences the pipeline response to branch-unit results in the EXE stage. Compares the resolved branch target from the branch functional unit with the PC that fetch actually followed. On a mismatch it issues a redirect to fetch with a valid/ready handshake and holds a flush of the younger stages. On a misaligned target it raises an exception request instead. Sits between EXE and the IF/ID stage control logic.

---
 rtl/br_redirect_ctrl.sv | 77 +++++++
 tb/tb_br_redirect_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/br_redirect_ctrl.sv
// br_redirect_ctrl: EXE branch redirect/misalign-exception sequencer with flush hold; define BR_STATS_EN for branch/mispredict counters
module br_redirect_ctrl #(
  parameter int PC_SZ = 32,
  parameter int FLUSH_CYCLES = 2
`ifdef BR_STATS_EN
  , parameter int CNT_SZ = 32
`endif
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             exe_valid,
  input  logic             exe_is_br,
  input  logic [PC_SZ-1:0] exe_pred_pc,
  input  logic [PC_SZ-1:0] bfu_br_pc,
  input  logic             bfu_mis,
  output logic             rd_valid,
  output logic [PC_SZ-1:0] rd_pc,
  input  logic             rd_ready,
  output logic             exc_req,
  output logic [PC_SZ-1:0] exc_addr,
  input  logic             exc_ack,
  output logic             flush_out,
  output logic             busy
`ifdef BR_STATS_EN
  , output logic [CNT_SZ-1:0] br_cnt
  , output logic [CNT_SZ-1:0] mp_cnt
  , input  logic              stats_clr
`endif
);
  localparam int DW = $clog2(FLUSH_CYCLES) > 0 ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, REDIRECT, EXC, DRAIN} state_t;
  state_t state, state_nx;
  logic [DW-1:0] drain_cnt;
  logic ev, pc_miss, take;
  assign ev = exe_valid & exe_is_br & (state == IDLE);
  assign pc_miss = bfu_br_pc != exe_pred_pc;
  assign take = ev & (bfu_mis | pc_miss);
  // state register
  always_ff @(posedge clk_in)
    if (!reset_in) state <= IDLE;
    else state <= state_nx;
  // next state: misalignment beats mispredict; handshakes only count in their own state
  always_comb begin
    state_nx = take ? (bfu_mis ? EXC : REDIRECT) :
               ((state == REDIRECT) & rd_ready) | ((state == EXC) & exc_ack) ? DRAIN :
               ((state == DRAIN) & (drain_cnt == '0)) ? IDLE : state;
  end
  // outputs decode straight from the registered state
  always_comb begin
    rd_valid  = state == REDIRECT;
    exc_req   = state == EXC;
    flush_out = state != IDLE;
    busy      = state != IDLE;
  end
  // target capture and drain countdown; counter preloads whenever not draining
  always_ff @(posedge clk_in)
    if (!reset_in) begin
      rd_pc     <= '0;
      exc_addr  <= '0;
      drain_cnt <= '0;
    end else begin
      if (ev & bfu_mis) exc_addr <= bfu_br_pc;
      if (ev & !bfu_mis & pc_miss) rd_pc <= bfu_br_pc;
      drain_cnt <= state == DRAIN ? drain_cnt - DW'(1) : DW'(FLUSH_CYCLES - 1);
    end
`ifdef BR_STATS_EN
  // statistics: clear wins over a same-cycle increment
  always_ff @(posedge clk_in)
    if (!reset_in | stats_clr) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (ev) begin
      br_cnt <= br_cnt + CNT_SZ'(1);
      if (take) mp_cnt <= mp_cnt + CNT_SZ'(1);
    end
`endif
endmodule

// File: tb/tb_br_redirect_ctrl.sv
// tb_br_redirect_ctrl: directed vectors with a cycle-tagged expectation queue checked by a separate monitor
module tb_br_redirect_ctrl;
  logic clk_in = 0, reset_in = 0;
  logic exe_valid = 0, exe_is_br = 0, bfu_mis = 0, rd_ready = 0, exc_ack = 0, stats_clr = 0;
  logic [31:0] exe_pred_pc = 0, bfu_br_pc = 0;
  logic rd_valid, exc_req, flush_out, busy;
  logic [31:0] rd_pc, exc_addr;
  logic [3:0] br_cnt, mp_cnt;
  int cyc = 0, n_vec = 0, n_miss = 0;

  typedef struct {
    int cyc;
    logic rv;
    logic [31:0] rpc;
    logic er;
    logic [31:0] ea;
    logic fl;
    logic [3:0] bc;
    logic [3:0] mc;
    string nm;
  } exp_t;
  exp_t q[$];

  br_redirect_ctrl #(
    .PC_SZ(32),
    .FLUSH_CYCLES(2)
`ifdef BR_STATS_EN
    , .CNT_SZ(4)
`endif
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .exe_valid(exe_valid), .exe_is_br(exe_is_br),
    .exe_pred_pc(exe_pred_pc), .bfu_br_pc(bfu_br_pc), .bfu_mis(bfu_mis),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_ready(rd_ready),
    .exc_req(exc_req), .exc_addr(exc_addr), .exc_ack(exc_ack),
    .flush_out(flush_out), .busy(busy)
`ifdef BR_STATS_EN
    , .br_cnt(br_cnt), .mp_cnt(mp_cnt), .stats_clr(stats_clr)
`endif
  );

`ifndef BR_STATS_EN
  assign br_cnt = '0;
  assign mp_cnt = '0;
`endif

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s.%s cycle %0d: got %h, expected %h", nm, fld, cyc, act, req);
    end
  endtask

  // monitor: compare every expectation tagged for the current cycle
  initial forever begin
    @(negedge clk_in);
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "rd_valid", 32'(rd_valid), 32'(e.rv));
      chk(e.nm, "rd_pc", rd_pc, e.rpc);
      chk(e.nm, "exc_req", 32'(exc_req), 32'(e.er));
      chk(e.nm, "exc_addr", exc_addr, e.ea);
      chk(e.nm, "flush_out", 32'(flush_out), 32'(e.fl));
      chk(e.nm, "busy", 32'(busy), 32'(e.fl));
`ifdef BR_STATS_EN
      chk(e.nm, "br_cnt", 32'(br_cnt), 32'(e.bc));
      chk(e.nm, "mp_cnt", 32'(mp_cnt), 32'(e.mc));
`endif
    end
  end

  // drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic vec(input logic rn, input logic [1:0] vb, input logic mis, input logic [31:0] bpc,
                     input logic [31:0] ppc, input logic rdy, input logic ack, input logic clr,
                     input logic e_rv, input logic [31:0] e_rpc, input logic e_er, input logic [31:0] e_ea,
                     input logic e_fl, input logic [3:0] e_bc, input logic [3:0] e_mc, input string nm);
    exp_t e;
    reset_in = rn;
    {exe_valid, exe_is_br} = vb;
    bfu_mis = mis;
    bfu_br_pc = bpc;
    exe_pred_pc = ppc;
    rd_ready = rdy;
    exc_ack = ack;
    stats_clr = clr;
    e = '{cyc + 1, e_rv, e_rpc, e_er, e_ea, e_fl, e_bc, e_mc, nm};
    q.push_back(e);
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [31:0] p;
    @(posedge clk_in);
    #1;
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst1");
    vec(1, 3, 0, 'h1008, 'h1008, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "hit");
    vec(1, 2, 0, 'h2000, 'h1004, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "not_br");
    vec(1, 1, 0, 'h2000, 'h1004, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "not_valid");
    vec(1, 3, 0, 'h2000, 'h1004, 0, 0, 0, 1, 'h2000, 0, 0, 1, 2, 1, "mp");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 'h2000, 0, 0, 1, 2, 1, "stall1");
    vec(1, 3, 0, 'h3000, 'h1234, 0, 0, 0, 1, 'h2000, 0, 0, 1, 2, 1, "stall2_wp");
    vec(1, 0, 0, 0, 0, 0, 1, 0, 1, 'h2000, 0, 0, 1, 2, 1, "stall3_ack");
    vec(1, 0, 0, 0, 0, 1, 0, 0, 0, 'h2000, 0, 0, 1, 2, 1, "accept");
    vec(1, 3, 0, 'h3000, 'h1234, 0, 0, 0, 0, 'h2000, 0, 0, 1, 2, 1, "drain_wp");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h2000, 0, 0, 0, 2, 1, "idle1");
    vec(1, 3, 1, 'h2002, 'h2002, 1, 0, 0, 0, 'h2000, 1, 'h2002, 1, 3, 2, "misal");
    vec(1, 0, 0, 0, 0, 1, 0, 0, 0, 'h2000, 1, 'h2002, 1, 3, 2, "exc_rdy");
    vec(1, 0, 0, 0, 0, 0, 1, 0, 0, 'h2000, 0, 'h2002, 1, 3, 2, "exc_ack");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h2000, 0, 'h2002, 1, 3, 2, "exc_drain");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h2000, 0, 'h2002, 0, 3, 2, "exc_idle");
    vec(1, 3, 1, 'h4006, 'h5000, 0, 0, 0, 0, 'h2000, 1, 'h4006, 1, 4, 3, "mis_prio");
    vec(1, 0, 0, 0, 0, 0, 1, 0, 0, 'h2000, 0, 'h4006, 1, 4, 3, "ack2");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h2000, 0, 'h4006, 1, 4, 3, "drain2");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h2000, 0, 'h4006, 0, 4, 3, "idle2");
    vec(1, 3, 0, 'h6000, 'h6004, 0, 0, 0, 1, 'h6000, 0, 'h4006, 1, 5, 4, "mp2");
    for (int i = 0; i < 3; i++)
      vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_mid");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_rel");
    vec(1, 3, 0, 'h80001000, 'h00001000, 0, 0, 0, 1, 'h80001000, 0, 0, 1, 1, 1, "msb");
    vec(1, 0, 0, 0, 0, 1, 0, 0, 0, 'h80001000, 0, 0, 1, 1, 1, "acc3");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h80001000, 0, 0, 1, 1, 1, "dr3");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h80001000, 0, 0, 0, 1, 1, "idle3");
    vec(1, 0, 0, 0, 0, 0, 0, 1, 0, 'h80001000, 0, 0, 0, 0, 0, "clr");
    for (int i = 0; i < 16; i++) begin
      p = 32'hA000 + 32'(i) * 16;
      vec(1, 3, 0, p, p + 4, 0, 0, 0, 1, p, 0, 0, 1, 4'(i + 1), 4'(i + 1), "wrap_mp");
      vec(1, 0, 0, 0, 0, 1, 0, 0, 0, p, 0, 0, 1, 4'(i + 1), 4'(i + 1), "wrap_acc");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, p, 0, 0, 1, 4'(i + 1), 4'(i + 1), "wrap_dr");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, p, 0, 0, 0, 4'(i + 1), 4'(i + 1), "wrap_idle");
    end
    vec(1, 3, 0, 'h7000, 'h7008, 0, 0, 1, 1, 'h7000, 0, 0, 1, 0, 0, "clr_ev");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 'h7000, 0, 0, 1, 0, 0, "clr_hold");
    repeat (3) @(posedge clk_in);
    if (q.size() > 0) begin
      n_miss += q.size();
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
